cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares the single main-memory port between the instruction cache and the data cache. It serializes block refills (multi-beat reads) and write-through stores (single-beat writes) using round-robin arbitration. It sits between both caches' miss/write paths and the main memory model, and drives the per-requester data beats and completion pulses that release cache stalls.

## Interface
- ADDR_W, 64, address width (byte address)
- DATA_W, 64, memory beat width
- BLOCK_BYTES, 16, cache block size; BEATS = BLOCK_BYTES/(DATA_W/8) = 2
---
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_req  in  1  icache refill request, level, held until i_done
- i_addr  in  ADDR_W  icache miss address
- i_rdata  out  DATA_W  refill beat to icache
- i_rvalid  out  1  one-cycle strobe per beat
- i_done  out  1  one-cycle pulse, transaction complete
- d_req  in  1  dcache request, level, held until d_done
- d_we  in  1  1 = write-through store (1 beat), 0 = block refill
- d_addr  in  ADDR_W  dcache address
- d_wdata  in  DATA_W  store data
- d_rdata, d_rvalid, d_done  out  DATA_W/1/1  as the icache equivalents
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  beat address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- mem_ready  in  1  beat accepted/complete this cycle
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE, BUSY, DONE.
- IDLE: if no request, stay. If exactly one request, grant it. If both request, grant the one not in last_grant. On grant:
  - latch owner, we, wdata.
  - base = addr with low log2(BLOCK_BYTES) bits cleared for refills; addr with low 3 bits cleared for writes.
  - beat = 0; update last_grant; go to BUSY.
- BUSY: mem_req = 1, mem_addr = base + 8*beat, mem_we = latched we, mem_wdata = latched wdata. mem_req and mem_addr are held stable until mem_ready.
  - On a read with mem_ready: register mem_rdata into owner's rdata and pulse owner's rvalid next cycle; beat++.
  - Last beat: go to DONE when beat == BEATS-1 for reads, or on the first mem_ready for writes.
- DONE: pulse the owner's done for one cycle; mem_req = 0; go to IDLE.
- The final read beat's rvalid coincides with done.
- Requester inputs are ignored outside IDLE. The non-owner's outputs stay 0.
- Write addresses are forced to 8-byte alignment. Refill beats wrap within the block starting at offset 0 (no critical-word-first).
- mem_ready while not in BUSY is ignored.
- Reset, at any time including mid-transaction, produces:
  - state IDLE, beat 0, last_grant = icache (so the first tie goes to dcache).
  - all outputs 0; rdata registers cleared.
  - any in-flight beat is abandoned with no done pulse.

## Timing
- Request high at edge t (IDLE) -> mem_req high from cycle t+1.
- Zero-wait memory (mem_ready = 1 while mem_req): refill has mem_req for BEATS cycles, rvalid on cycles t+2..t+1+BEATS, and done at t+1+BEATS. A write has done at t+2.
- Each wait cycle of mem_ready adds exactly one cycle.
- IDLE re-entered the cycle after done. The requester drops req on the cycle it sees done, so no double grant occurs.
- Back-to-back: the minimum gap between one mem_req burst and the next is 2 cycles (DONE, IDLE).

## Structure
- Package cache_mem_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - owner enum {OWN_I, OWN_D};
  - BLOCK_BYTES, BEAT_BYTES, BEATS, and the beat counter width $clog2(BEATS).
- Sub-module mem_rr_arb: a 2-input round-robin grant with last_grant register and update-enable. Everything else is in the top.

## Test plan
- i_req alone, i_addr=0x13C, zero-wait memory with mem returning 0xA, 0xB -> mem_addr 0x130 then 0x138; i_rvalid with i_rdata 0xA, 0xB; i_done with the second beat; d outputs stay 0.
- d_req with d_we=1, d_addr=0x40, d_wdata=0x1122334455667788, mem_ready delayed 3 cycles -> mem_we=1, mem_addr 0x40 held 4 cycles; d_done on the cycle after ready; no d_rvalid.
- i_req and d_req raised on the same cycle after reset -> dcache granted first, icache next; with both held continuously, grants alternate.
- Reset asserted while BUSY on beat 1 of a refill -> next cycle: IDLE, mem_req=0, no done pulse, busy=0, last_grant restored so a tie grants dcache.
- mem_ready pulsed while IDLE, and held high on the DONE cycle -> no rvalid/done generated, beat count unaffected.
- Refill at d_addr=0xFF8 -> beats at 0xFF0, 0xFF8; no carry into the next block.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared types and block geometry for the cache-to-memory arbiter.
package cache_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BEAT_BYTES  = 8;
    localparam int unsigned BEATS       = BLOCK_BYTES / BEAT_BYTES;
    localparam int unsigned BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin grant: a tie goes to whichever requester was not granted last.
module mem_rr_arb
    import cache_mem_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   update,
    output logic   grant_valid,
    output owner_t grant
);

    owner_t last_grant;

    always_comb begin
        grant_valid = i_req | d_req;
        if (i_req && d_req)
            grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
        else
            grant = d_req ? OWN_D : OWN_I;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= OWN_I;
        else if (update)
            last_grant <= grant;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serialises icache refills and dcache refills/write-through stores onto one memory port.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned BLOCK_BYTES = cache_mem_pkg::BLOCK_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);
    import cache_mem_pkg::*;

    localparam int unsigned       BEAT_SZ   = DATA_W / 8;
    localparam int unsigned       NBEATS    = BLOCK_BYTES / BEAT_SZ;
    localparam int unsigned       CNT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(BLOCK_BYTES - 1);
    localparam logic [ADDR_W-1:0] BEAT_MASK = ~ADDR_W'(BEAT_SZ - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NBEATS - 1);

    state_t            state;
    owner_t            owner;
    owner_t            grant;
    logic              grant_valid;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  beat;
    logic [CNT_W-1:0]  beat_inc;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [ADDR_W-1:0] base_next;

    mem_rr_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .d_req       (d_req),
        .update      ((state == IDLE) && grant_valid),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Stores only need beat alignment; refills always start at the block base.
    always_comb begin
        sel_addr  = (grant == OWN_D) ? d_addr : i_addr;
        sel_we    = (grant == OWN_D) && d_we;
        base_next = sel_we ? (sel_addr & BEAT_MASK) : (sel_addr & BLK_MASK);
        beat_inc  = beat + CNT_W'(1);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_I;
            base_q    <= '0;
            beat      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant;
                        mem_we    <= sel_we;
                        mem_wdata <= (grant == OWN_D) ? d_wdata : '0;
                        base_q    <= base_next;
                        mem_addr  <= base_next;
                        beat      <= '0;
                        mem_req   <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            if (owner == OWN_D) begin
                                d_rdata  <= mem_rdata;
                                d_rvalid <= 1'b1;
                            end else begin
                                i_rdata  <= mem_rdata;
                                i_rvalid <= 1'b1;
                            end
                        end
                        if (mem_we || beat == LAST_BEAT) begin
                            state     <= DONE;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= '0;
                            if (owner == OWN_D) d_done <= 1'b1;
                            else                i_done <= 1'b1;
                        end else begin
                            beat     <= beat_inc;
                            mem_addr <= base_q + ADDR_W'(beat_inc) * ADDR_W'(BEAT_SZ);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts memory beats, read data and done pulses.
module tb_cache_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } txn_t;

    typedef struct {
        bit          own_d;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [63:0] i_addr, d_addr, d_wdata;
    logic [63:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        i_rvalid, i_done, d_rvalid, d_done, mem_req, mem_we, busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [63:0] salt;
    bit          model_last_d = 1'b0;
    beat_t       exp_mem[$];
    logic [63:0] exp_i_rd[$];
    logic [63:0] exp_d_rd[$];

    cache_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .BLOCK_BYTES(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return (a * 64'h9E3779B97F4A7C15) ^ salt;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name, input logic [63:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %h, required nothing", name, act);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory model: random (or fixed) wait states, data is a fixed function of address.
    int          fixed_wait = -1;
    bit          idle_ready_all = 1'b0;
    int unsigned wait_cnt = 0;

    function automatic int unsigned pick_wait();
        return (fixed_wait >= 0) ? unsigned'(fixed_wait) : $urandom_range(0, 3);
    endfunction

    always @(posedge clk) begin
        #1;
        if (mem_req === 1'b1) begin
            if (wait_cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_data(mem_addr);
                wait_cnt  = pick_wait();
            end else begin
                wait_cnt--;
                mem_ready = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
        end else begin
            mem_ready = idle_ready_all || ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom};
            wait_cnt  = pick_wait();
        end
    end

    // Monitor
    int          cyc = 0;
    int          rv_due = -1;
    int          done_due = -1;
    bit          rv_d, done_d;
    bit          prev_wait = 1'b0;
    logic [63:0] prev_addr;
    beat_t       mon_e;
    logic        exp_iv, exp_dv, exp_id, exp_dd;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            exp_mem.delete();
            exp_i_rd.delete();
            exp_d_rd.delete();
            rv_due    = -1;
            done_due  = -1;
            prev_wait = 1'b0;
        end else begin
            exp_iv = (rv_due == cyc) && !rv_d;
            exp_dv = (rv_due == cyc) && rv_d;
            exp_id = (done_due == cyc) && !done_d;
            exp_dd = (done_due == cyc) && done_d;
            if (i_rvalid || exp_iv) begin
                check("i_rvalid", 64'(i_rvalid), 64'(exp_iv));
                if (i_rvalid) begin
                    if (exp_i_rd.size() == 0) fail_note("i_rdata_extra", i_rdata);
                    else check("i_rdata", i_rdata, exp_i_rd.pop_front());
                end
            end
            if (d_rvalid || exp_dv) begin
                check("d_rvalid", 64'(d_rvalid), 64'(exp_dv));
                if (d_rvalid) begin
                    if (exp_d_rd.size() == 0) fail_note("d_rdata_extra", d_rdata);
                    else check("d_rdata", d_rdata, exp_d_rd.pop_front());
                end
            end
            if (i_done || exp_id) check("i_done", 64'(i_done), 64'(exp_id));
            if (d_done || exp_dd) check("d_done", 64'(d_done), 64'(exp_dd));
            if (mem_req || i_done || d_done) check("busy", 64'(busy), 64'd1);
            if (prev_wait) begin
                check("mem_req_hold", 64'(mem_req), 64'd1);
                check("mem_addr_hold", mem_addr, prev_addr);
            end
            if (mem_req && mem_ready) begin
                if (exp_mem.size() == 0) begin
                    fail_note("mem_beat_extra", mem_addr);
                end else begin
                    mon_e = exp_mem.pop_front();
                    check("mem_addr", mem_addr, mon_e.addr);
                    check("mem_we", 64'(mem_we), 64'(mon_e.we));
                    if (mon_e.we) check("mem_wdata", mem_wdata, mon_e.wdata);
                    if (!mon_e.we) begin
                        rv_due = cyc + 1;
                        rv_d   = mon_e.own_d;
                    end
                    if (mon_e.last) begin
                        done_due = cyc + 1;
                        done_d   = mon_e.own_d;
                    end
                end
            end
            prev_wait = mem_req && !mem_ready;
            prev_addr = mem_addr;
        end
    end

    // Reference model: a store is one beat at the 8-byte-aligned address; a refill is
    // two beats at block base and base+8, with data delivered to the owner.
    task automatic push_txn(input txn_t t, input bit own_d);
        beat_t       e;
        logic [63:0] base;
        e.own_d = own_d;
        e.we    = t.we;
        e.wdata = t.wdata;
        if (t.we) begin
            e.addr = t.addr & ~64'h7;
            e.last = 1'b1;
            exp_mem.push_back(e);
        end else begin
            base = t.addr & ~64'hF;
            for (int k = 0; k < 2; k++) begin
                e.addr = base + 64'(8 * k);
                e.last = (k == 1);
                exp_mem.push_back(e);
                if (own_d) exp_d_rd.push_back(mem_data(e.addr));
                else       exp_i_rd.push_back(mem_data(e.addr));
            end
        end
    endtask

    task automatic requester(input bit side, input txn_t q[$]);
        int unsigned n;
        foreach (q[k]) begin
            if (side) begin
                d_req = 1'b1; d_we = q[k].we; d_addr = q[k].addr; d_wdata = q[k].wdata;
            end else begin
                i_req = 1'b1; i_addr = q[k].addr;
            end
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!(side ? d_done : i_done) && n < 200);
            if (n >= 200) fail_note(side ? "d_done_timeout" : "i_done_timeout", 64'(n));
            if (side) d_req = 1'b0;
            else      i_req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // Both sides keep requesting until their lists are empty; ties alternate.
    task automatic run_phase(input txn_t ti[$], input txn_t td[$]);
        int a = 0;
        int b = 0;
        bit pick_d;
        while (a < ti.size() || b < td.size()) begin
            if (a < ti.size() && b < td.size()) pick_d = !model_last_d;
            else                                pick_d = (b < td.size());
            if (pick_d) begin push_txn(td[b], 1'b1); b++; end
            else        begin push_txn(ti[a], 1'b0); a++; end
            model_last_d = pick_d;
        end
        fork
            requester(1'b0, ti);
            requester(1'b1, td);
        join
    endtask

    task automatic watch(input string name, input bit side,
                         input int unsigned exp_req, input int unsigned exp_done);
        int unsigned n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mem_req && n < 50);
        check({name, "_req_latency"}, 64'(n), 64'(exp_req));
        while (!(side ? d_done : i_done) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done_latency"}, 64'(n), 64'(exp_done));
    endtask

    initial begin
        txn_t ti[$];
        txn_t td[$];
        txn_t t;
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        salt = {$urandom, $urandom};
        tick(3);
        reset = 1'b0;
        model_last_d = 1'b0;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_i_rdata", i_rdata, 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        check("rst_strobes", 64'({i_rvalid, i_done, d_rvalid, d_done}), 64'd0);

        // icache refill, zero-wait memory, ready also high while idle/done
        fixed_wait = 0; idle_ready_all = 1'b1;
        tick(1);
        ti.delete(); td.delete();
        t.we = 1'b0; t.addr = 64'h13C; t.wdata = '0; ti.push_back(t);
        fork
            run_phase(ti, td);
            watch("i_refill", 1'b0, 1, 3);
        join
        check("d_rdata_untouched", d_rdata, 64'd0);

        // write-through store with 3 wait states; address forced to 8-byte alignment
        fixed_wait = 3; idle_ready_all = 1'b0;
        tick(1);
        ti.delete(); td.delete();
        t.we = 1'b1; t.addr = 64'h45; t.wdata = 64'h1122334455667788; td.push_back(t);
        fork
            run_phase(ti, td);
            watch("d_write", 1'b1, 1, 5);
        join

        // dcache refill at the top of a block
        fixed_wait = -1;
        tick(1);
        ti.delete(); td.delete();
        t.we = 1'b0; t.addr = 64'hFF8; t.wdata = '0; td.push_back(t);
        run_phase(ti, td);

        // reset during beat 1 of a dcache refill
        fixed_wait = 2;
        tick(1);
        t.we = 1'b0; t.addr = 64'h2A8; push_txn(t, 1'b1);
        model_last_d = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h2A8;
        tick(4);
        check("mid_beat1_addr", mem_addr, 64'h2A8);
        reset = 1'b1; d_req = 1'b0;
        tick(1);
        reset = 1'b0;
        model_last_d = 1'b0;
        check("mid_rst_mem_req", 64'(mem_req), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_d_done", 64'(d_done), 64'd0);
        check("mid_rst_d_rdata", d_rdata, 64'd0);
        tick(3);

        // simultaneous requests after reset: dcache first, then alternation
        fixed_wait = -1;
        ti.delete(); td.delete();
        for (int k = 0; k < 2; k++) begin
            t.we = 1'b0; t.addr = 64'h1000 + 64'(k * 64); t.wdata = '0; ti.push_back(t);
            t.we = (k == 1); t.addr = 64'h2000 + 64'(k * 64); t.wdata = {$urandom, $urandom};
            td.push_back(t);
        end
        run_phase(ti, td);

        // randomized phases
        for (int p = 0; p < 40; p++) begin
            int unsigned ni, nd;
            ti.delete(); td.delete();
            ni = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            if (ni + nd == 0) nd = 1;
            for (int k = 0; k < int'(ni); k++) begin
                t.we = 1'b0; t.addr = {$urandom, $urandom}; t.wdata = '0; ti.push_back(t);
            end
            for (int k = 0; k < int'(nd); k++) begin
                t.we = $urandom_range(0, 1); t.addr = {$urandom, $urandom};
                t.wdata = {$urandom, $urandom}; td.push_back(t);
            end
            run_phase(ti, td);
        end

        tick(4);
        check("scoreboard_drained", 64'(exp_mem.size() + exp_i_rd.size() + exp_d_rd.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
